// File: rtl/approx_adder_err_eval.sv
// Exhaustive operand sweep driver and error accumulator for a W-bit approximate adder.
// Optional worst-case operand capture (wce_a_o/wce_b_o) is enabled by ERR_EVAL_WCE_CAPTURE_EN.
module approx_adder_err_eval #(
  parameter int W       = 8,
  parameter int ACC_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic [W-1:0]     op_a_o,
  output logic [W-1:0]     op_b_o,
  output logic             op_valid_o,
  input  logic [W:0]       res_i,
  input  logic             res_valid_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [ACC_W-1:0] err_count_o,
  output logic [ACC_W-1:0] sum_abs_err_o,
`ifdef ERR_EVAL_WCE_CAPTURE_EN
  output logic [W-1:0]     wce_a_o,
  output logic [W-1:0]     wce_b_o,
`endif
  output logic [W:0]       max_abs_err_o
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [2*W-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic [W:0]       exact_q, exact_d;
  logic [W:0]       res_q, res_d;
  logic [ACC_W-1:0] err_q, err_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [W:0]       max_q, max_d;
  logic             done_q, done_d;
  logic             to_q, to_d;
`ifdef ERR_EVAL_WCE_CAPTURE_EN
  logic [W-1:0]     wce_a_q, wce_a_d;
  logic [W-1:0]     wce_b_q, wce_b_d;
`endif

  // Signed difference in W+2 bits, folded to an unsigned W+1-bit magnitude.
  logic [W+1:0]     diff, diff_neg;
  logic [W:0]       abs_d;
  logic [ACC_W:0]   sum_ext;

  assign diff     = {1'b0, res_q} - {1'b0, exact_q};
  assign diff_neg = -diff;
  assign abs_d    = diff[W+1] ? diff_neg[W:0] : diff[W:0];
  assign sum_ext  = {1'b0, sum_q} + (ACC_W+1)'(abs_d);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    exact_d = exact_q;
    res_d   = res_q;
    err_d   = err_q;
    sum_d   = sum_q;
    max_d   = max_q;
    done_d  = done_q;
    to_d    = to_q;
`ifdef ERR_EVAL_WCE_CAPTURE_EN
    wce_a_d = wce_a_q;
    wce_b_d = wce_b_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
          err_d   = '0;
          sum_d   = '0;
          max_d   = '0;
          done_d  = 1'b0;
          to_d    = 1'b0;
`ifdef ERR_EVAL_WCE_CAPTURE_EN
          wce_a_d = '0;
          wce_b_d = '0;
`endif
        end
      end
      S_ISSUE: begin
        exact_d = {1'b0, cnt_q[W-1:0]} + {1'b0, cnt_q[2*W-1:W]};
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (res_valid_i) begin
          res_d   = res_i;
          state_d = S_ACC;
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
      end
      S_ACC: begin
        if (abs_d != '0) err_d = err_q + 1'b1;
        sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
        if (abs_d > max_q) begin
          max_d   = abs_d;
`ifdef ERR_EVAL_WCE_CAPTURE_EN
          wce_a_d = cnt_q[W-1:0];
          wce_b_d = cnt_q[2*W-1:W];
`endif
        end
        // The last pair ends the sweep; the counter is never wrapped back to 0.
        if (&cnt_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      exact_q <= '0;
      res_q   <= '0;
      err_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
`ifdef ERR_EVAL_WCE_CAPTURE_EN
      wce_a_q <= '0;
      wce_b_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      exact_q <= exact_d;
      res_q   <= res_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      done_q  <= done_d;
      to_q    <= to_d;
`ifdef ERR_EVAL_WCE_CAPTURE_EN
      wce_a_q <= wce_a_d;
      wce_b_q <= wce_b_d;
`endif
    end
  end

  assign op_a_o        = cnt_q[W-1:0];
  assign op_b_o        = cnt_q[2*W-1:W];
  assign op_valid_o    = (state_q == S_ISSUE);
  assign busy_o        = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_ACC);
  assign done_o        = done_q;
  assign timeout_o     = to_q;
  assign err_count_o   = err_q;
  assign sum_abs_err_o = sum_q;
  assign max_abs_err_o = max_q;
`ifdef ERR_EVAL_WCE_CAPTURE_EN
  assign wce_a_o       = wce_a_q;
  assign wce_b_o       = wce_b_q;
`endif

endmodule

// File: tb/tb_approx_adder_err_eval.sv
// Bench for approx_adder_err_eval at W=4: a stub approximate adder with selectable faults,
// random latency and random error table, checked against an arithmetic sweep model.
module tb_approx_adder_err_eval;
  localparam int W       = 4;
  localparam int ACC_W   = 10;
  localparam int TIMEOUT = 255;
  localparam int NP      = 1 << (2 * W);
  localparam int SATMAX  = (1 << ACC_W) - 1;

  logic             clk = 0;
  logic             rst;
  logic             start;
  logic [W-1:0]     op_a, op_b;
  logic             op_valid;
  logic [W:0]       res;
  logic             res_valid;
  logic             busy, done, timeout;
  logic [ACC_W-1:0] err_count, sum_abs_err;
  logic [W:0]       max_abs_err;
`ifdef ERR_EVAL_WCE_CAPTURE_EN
  logic [W-1:0]     wce_a, wce_b;
`endif

  approx_adder_err_eval #(.W(W), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .op_a_o(op_a), .op_b_o(op_b), .op_valid_o(op_valid),
    .res_i(res), .res_valid_i(res_valid),
    .busy_o(busy), .done_o(done), .timeout_o(timeout),
    .err_count_o(err_count), .sum_abs_err_o(sum_abs_err),
`ifdef ERR_EVAL_WCE_CAPTURE_EN
    .wce_a_o(wce_a), .wce_b_o(wce_b),
`endif
    .max_abs_err_o(max_abs_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Stub-adder configuration, written only by the main initial block.
  int         mode = 0;
  int         lat_max = 1;
  bit         respond_en = 1;
  bit         spur_en = 0;
  logic [W:0] tab [NP];

  function automatic logic [W:0] resp(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] e;
    logic [2*W-1:0] idx;
    e = {1'b0, a} + {1'b0, b};
    idx = {b, a};
    case (m)
      1:       return {e[W:1], 1'b0};
      2:       return {1'b0, e[W-1:0]};
      3:       return e ^ tab[idx];
      default: return e;
    endcase
  endfunction

  // Stub approximate adder: answers each op_valid after a random latency.
  int         pend = 0;
  logic [W-1:0] cap_a, cap_b;
  always @(negedge clk) begin
    res_valid = 1'b0;
    if (rst) pend = 0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        res_valid = 1'b1;
        res = resp(mode, cap_a, cap_b);
      end
    end
    if (op_valid && !rst) begin
      cap_a = op_a;
      cap_b = op_b;
      if (respond_en) pend = $urandom_range(lat_max, 1);
      if (spur_en) begin
        res_valid = 1'b1;
        res = ~resp(mode, op_a, op_b);
      end
    end
  end

  // Reference: plain arithmetic over every operand pair in sweep order.
  int m_err, m_sum, m_max, m_wa, m_wb;
  task automatic model(input int m);
    int e, r, d;
    m_err = 0; m_sum = 0; m_max = 0; m_wa = 0; m_wb = 0;
    for (int i = 0; i < NP; i++) begin
      e = (i % (1 << W)) + (i / (1 << W));
      r = int'(resp(m, W'(i % (1 << W)), W'(i / (1 << W))));
      d = (r > e) ? r - e : e - r;
      if (d != 0) m_err++;
      m_sum += d;
      if (d > m_max) begin m_max = d; m_wa = i % (1 << W); m_wb = i / (1 << W); end
    end
    if (m_sum > SATMAX) m_sum = SATMAX;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  int cycles;
  task automatic start_and_wait(input bit poke);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < 6000) begin
      start = (poke && (cycles % 37 == 5));
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    chk("done_reached", done, 1);
  endtask

  task automatic check_totals(input string tag);
    chk({tag, "_err"}, err_count, m_err);
    chk({tag, "_sum"}, sum_abs_err, m_sum);
    chk({tag, "_max"}, max_abs_err, m_max);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef ERR_EVAL_WCE_CAPTURE_EN
    chk({tag, "_wce_a"}, wce_a, m_wa);
    chk({tag, "_wce_b"}, wce_b, m_wb);
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_op_a"}, op_a, 0);
    chk({tag, "_op_b"}, op_b, 0);
    chk({tag, "_op_valid"}, op_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_sum"}, sum_abs_err, 0);
    chk({tag, "_max"}, max_abs_err, 0);
`ifdef ERR_EVAL_WCE_CAPTURE_EN
    chk({tag, "_wce_a"}, wce_a, 0);
    chk({tag, "_wce_b"}, wce_b, 0);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; res = '0; res_valid = 1'b0;
    for (int i = 0; i < NP; i++)
      tab[i] = ($urandom_range(1, 0) == 0) ? '0 : (W+1)'($urandom);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    // Exact adder, 1-cycle latency: error-free and 3 cycles per pair.
    mode = 0; lat_max = 1; model(0);
    start_and_wait(0);
    chk("exact_cycles", cycles, 3 * NP + 1);
    check_totals("exact");
    chk("exact_op_a_last", op_a, (1 << W) - 1);

    // LSB stuck at 0, random latency.
    mode = 1; lat_max = 4; model(1);
    start_and_wait(0);
    check_totals("lsb0");

    // Carry-out stuck at 0: sum saturates at the narrow accumulator width.
    mode = 2; lat_max = 2; model(2);
    start_and_wait(0);
    check_totals("cout0");

    // Random error table.
    mode = 3; lat_max = 3; model(3);
    start_and_wait(0);
    check_totals("rand");

    // Stub never answers: first WAIT runs out after TIMEOUT cycles.
    respond_en = 0;
    start_and_wait(0);
    chk("to_cycles", cycles, TIMEOUT + 2);
    chk("to_flag", timeout, 1);
    chk("to_busy", busy, 0);
    chk("to_op_a", op_a, 0);
    chk("to_op_b", op_b, 0);
    chk("to_err", err_count, 0);
    respond_en = 1;

    // Reset while waiting on pair 100, then a clean rerun of the LSB fault.
    mode = 1; lat_max = 3; model(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!(op_valid && {op_b, op_a} == 100) && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    chk("reach_pair100", {op_b, op_a}, 100);
    @(negedge clk);
    chk("pair100_wait", busy, 1);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("midrst_idle");
    start_and_wait(0);
    check_totals("rerun");

    // Start pulses while busy and spurious res_valid in ISSUE are ignored.
    mode = 0; lat_max = 1; spur_en = 1; model(0);
    start_and_wait(1);
    chk("spur_cycles", cycles, 3 * NP + 1);
    check_totals("spur");
    spur_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
